// File: rtl/fp_align_unit.sv
// Floating-point operand alignment: selects the larger-exponent operand and right-shifts the
// other mantissa one bit per cycle, folding shifted-out bits into guard/round/sticky.
module fp_align_unit #(
  parameter int unsigned MAN_W = 24,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] man_big,
  output logic [MAN_W+2:0] man_small,
  output logic             swap
);

  localparam int unsigned SmW      = MAN_W + 3;
  localparam int unsigned MaxShift = MAN_W + 2;
  localparam int unsigned CntW     = $clog2(MAN_W + 3);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] big_q, big_d;
  logic [SmW-1:0]   small_q, small_d;
  logic             swap_q, swap_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             a_big;
  logic [EXP_W-1:0] diff;
  logic [31:0]      diff_ext;
  logic [CntW-1:0]  shift_amt;

  // Ties keep A as the big operand.
  always_comb begin
    a_big     = (exp_a >= exp_b);
    diff      = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    diff_ext  = 32'(diff);
    // Beyond MaxShift every mantissa bit already lives in sticky, so clamp.
    shift_amt = (diff_ext > MaxShift) ? CntW'(MaxShift) : CntW'(diff_ext);
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    swap_d  = swap_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          exp_d   = a_big ? exp_a : exp_b;
          big_d   = a_big ? man_a : man_b;
          small_d = {(a_big ? man_b : man_a), 3'b000};
          swap_d  = ~a_big;
          cnt_d   = shift_amt;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          small_d = {1'b0, small_q[SmW-1:2], small_q[1] | small_q[0]};
          cnt_d   = cnt_q - CntW'(1);
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      swap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
      swap_q  <= swap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign exp_out   = exp_q;
  assign man_big   = big_q;
  assign man_small = small_q;
  assign swap      = swap_q;

endmodule

// File: tb/tb_fp_align_unit.sv
// Self-checking bench for fp_align_unit: directed vectors, handshake hold, reset abort,
// back-to-back operations and randomized operands against an arithmetic reference model.
module tb_fp_align_unit;

  localparam int MW = 24;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [EW-1:0] exp_a = '0, exp_b = '0;
  logic [MW-1:0] man_a = '0, man_b = '0;
  logic          in_ready, out_valid, swap;
  logic [EW-1:0] exp_out;
  logic [MW-1:0] man_big;
  logic [MW+2:0] man_small;

  int tests = 0;
  int fails = 0;

  fp_align_unit #(.MAN_W(MW), .EXP_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .man_a     (man_a),
    .man_b     (man_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_out   (exp_out),
    .man_big   (man_big),
    .man_small (man_small),
    .swap      (swap)
  );

  always #5 clk = ~clk;

  // Reference: aligning by n is a right shift by n with everything at or below bit n
  // OR-ed into the sticky position.
  function automatic void model(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                                output logic sw, output logic [EW-1:0] e,
                                output logic [MW-1:0] big, output logic [MW+2:0] sm,
                                output int lat);
    int d, n;
    longint unsigned ext, res, mask;
    sw  = (eb > ea);
    e   = sw ? eb : ea;
    big = sw ? mb : ma;
    d   = sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
    n   = (d > MW + 2) ? MW + 2 : d;
    ext = longint'(sw ? ma : mb) * 8;
    res = ext >> n;
    mask = (64'd1 << (n + 1)) - 1;
    if ((ext & mask) != 0) res = res | 64'd1;
    sm  = res[MW+2:0];
    lat = n + 1;
  endfunction

  task automatic drive_op(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from acceptance until out_valid; -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (swap !== 1'b0) begin fails++; $display("FAIL reset_swap got=%b exp=0", swap); end
    tests++; if (exp_out !== '0) begin fails++; $display("FAIL reset_exp_out got=%h exp=0", exp_out); end
    tests++; if (man_big !== '0) begin fails++; $display("FAIL reset_man_big got=%h exp=0", man_big); end
    tests++; if (man_small !== '0) begin fails++; $display("FAIL reset_man_small got=%h exp=0", man_small); end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [EW-1:0] vea [4] = '{8'h85, 8'h80, 8'h7F, 8'h90};
    logic [EW-1:0] veb [4] = '{8'h83, 8'h81, 8'h7F, 8'h10};
    logic [MW-1:0] vma [4] = '{24'hC00000, 24'hFFFFFF, 24'h900000, 24'hABCDEF};
    logic [MW-1:0] vmb [4] = '{24'h800000, 24'h800000, 24'hA00000, 24'h800001};
    logic          xsw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [EW-1:0] xe  [4] = '{8'h85, 8'h81, 8'h7F, 8'h90};
    logic [MW-1:0] xbg [4] = '{24'hC00000, 24'h800000, 24'h900000, 24'hABCDEF};
    logic [MW+2:0] xsm [4] = '{27'h1000000, 27'h3FFFFFC, 27'h5000000, 27'h0000001};
    int            xlt [4] = '{3, 2, 1, 27};
    int lat;
    for (int i = 0; i < 4; i++) begin
      drive_op(vea[i], veb[i], vma[i], vmb[i]);
      wait_done(lat);
      tests++; if (lat != xlt[i]) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, xlt[i]); end
      tests++; if (swap !== xsw[i]) begin fails++; $display("FAIL dir%0d_swap got=%b exp=%b", i, swap, xsw[i]); end
      tests++; if (exp_out !== xe[i]) begin fails++; $display("FAIL dir%0d_exp_out got=%h exp=%h", i, exp_out, xe[i]); end
      tests++; if (man_big !== xbg[i]) begin fails++; $display("FAIL dir%0d_man_big got=%h exp=%h", i, man_big, xbg[i]); end
      tests++; if (man_small !== xsm[i]) begin fails++; $display("FAIL dir%0d_man_small got=%h exp=%h", i, man_small, xsm[i]); end
      release_out;
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++; $display("FAIL dir%0d_release got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_hold;
    logic sw; logic [EW-1:0] e; logic [MW-1:0] bg; logic [MW+2:0] sm; int xl, lat;
    model(8'h7F, 8'h7F, 24'h900000, 24'hA00000, sw, e, bg, sm, xl);
    drive_op(8'h7F, 8'h7F, 24'h900000, 24'hA00000);
    wait_done(lat);
    tests++; if (lat != xl) begin fails++; $display("FAIL hold_latency got=%0d exp=%0d", lat, xl); end
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      exp_a = 8'($urandom); exp_b = 8'($urandom); man_a = 24'($urandom); man_b = 24'($urandom);
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_hs c=%0d got out_valid=%b in_ready=%b exp 1/0", c, out_valid, in_ready);
      end
      tests++; if (exp_out !== e || man_big !== bg || man_small !== sm || swap !== sw) begin
        fails++; $display("FAIL hold_data c=%0d got %h %h %h %b exp %h %h %h %b", c, exp_out, man_big,
                          man_small, swap, e, bg, sm, sw);
      end
    end
    in_valid = 1'b0;
    release_out;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL hold_exit got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hold_no_accept got in_ready=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_shift;
    int lat;
    drive_op(8'h90, 8'h10, 24'hABCDEF, 24'h800001);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_hs got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    tests++; if (exp_out !== '0 || man_big !== '0 || man_small !== '0 || swap !== 1'b0) begin
      fails++; $display("FAIL rstmid_outputs got %h %h %h %b exp all zero", exp_out, man_big, man_small, swap);
    end
    drive_op(8'h85, 8'h83, 24'hC00000, 24'h800000);
    wait_done(lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL rstmid_latency got=%0d exp=3", lat); end
    tests++; if (man_small !== 27'h1000000) begin
      fails++; $display("FAIL rstmid_man_small got=%h exp=1000000", man_small);
    end
    release_out;
  endtask

  task automatic test_back_to_back;
    logic sw; logic [EW-1:0] e; logic [MW-1:0] bg; logic [MW+2:0] sm; int xl, lat;
    drive_op(8'h40, 8'h44, 24'hF00000, 24'h812345);
    wait_done(lat);
    // Next operand offered while releasing; it must only be taken one edge later.
    exp_a = 8'h20; exp_b = 8'h28; man_a = 24'hFFFFFF; man_b = 24'h800000;
    model(8'h20, 8'h28, 24'hFFFFFF, 24'h800000, sw, e, bg, sm, xl);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_no_same_cycle got in_ready=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    tests++; if (lat != xl) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, xl); end
    tests++; if (man_small !== sm || exp_out !== e || swap !== sw || man_big !== bg) begin
      fails++; $display("FAIL b2b_data got %h %h %b %h exp %h %h %b %h", man_small, exp_out, swap, man_big,
                        sm, e, sw, bg);
    end
    release_out;
  endtask

  task automatic test_random;
    logic sw; logic [EW-1:0] e; logic [MW-1:0] bg; logic [MW+2:0] sm; int xl, n;
    logic [EW-1:0] ea, eb; logic [MW-1:0] ma, mb;
    for (int t = 0; t < 40; t++) begin
      ea = 8'($urandom);
      eb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(int'(ea) + $urandom_range(0, 30) - 15);
      ma = {1'b1, 23'($urandom)};
      mb = {1'b1, 23'($urandom)};
      model(ea, eb, ma, mb, sw, e, bg, sm, xl);
      drive_op(ea, eb, ma, mb);
      n = 0;
      while (!out_valid && n < 100) begin
        // Garbage offered during the shift must be ignored.
        in_valid = 1'($urandom);
        exp_a = 8'($urandom); exp_b = 8'($urandom); man_a = 24'($urandom); man_b = 24'($urandom);
        @(posedge clk); #1;
        n++;
        tests++; if (exp_out !== e || man_big !== bg || swap !== sw) begin
          fails++; $display("FAIL rnd%0d_stable n=%0d got %h %h %b exp %h %h %b", t, n, exp_out, man_big, swap,
                            e, bg, sw);
        end
      end
      in_valid = 1'b0;
      tests++; if (n != xl || !out_valid) begin fails++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, n, xl); end
      tests++; if (man_small !== sm) begin
        fails++; $display("FAIL rnd%0d_man_small ea=%h eb=%h got=%h exp=%h", t, ea, eb, man_small, sm);
      end
      release_out;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_reset_mid_shift;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
